// File: rtl/fib_batch_ctrl.sv
// rtl/fib_batch_ctrl.sv - batch sequencer driving a fib core, results buffered in an output FIFO
module fib_batch_ctrl #(
    parameter int INPUT_WIDTH  = 6,
    parameter int OUTPUT_WIDTH = 32,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [INPUT_WIDTH-1:0]  req_first,
    input  logic [INPUT_WIDTH-1:0]  req_last,
    output logic                    req_err,
    output logic                    fib_go,
    output logic [INPUT_WIDTH-1:0]  fib_n,
    input  logic                    fib_done,
    input  logic [OUTPUT_WIDTH-1:0] fib_result,
    input  logic                    fib_overflow,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [INPUT_WIDTH-1:0]  out_n,
    output logic [OUTPUT_WIDTH-1:0] out_result,
    output logic                    out_overflow,
    output logic                    out_last,
    output logic                    busy
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t                  state, state_nx;
    logic [INPUT_WIDTH:0]    n_cnt;
    logic [INPUT_WIDTH:0]    last_q;
    logic                    skip_q;
    logic                    pend_q;
    logic                    err_q;
    logic [INPUT_WIDTH-1:0]  st_n;
    logic [OUTPUT_WIDTH-1:0] st_result;
    logic                    st_ovf;
    logic                    st_last;

    logic [CW-1:0]           count;
    logic [PW-1:0]           rd_ptr, wr_ptr;
    logic [INPUT_WIDTH-1:0]  mem_n      [FIFO_DEPTH];
    logic [OUTPUT_WIDTH-1:0] mem_result [FIFO_DEPTH];
    logic                    mem_ovf    [FIFO_DEPTH];
    logic                    mem_last   [FIFO_DEPTH];

    logic accept, empty_req, room, capture, push, pop;

    assign accept    = (state == S_IDLE) && req_valid;
    assign empty_req = req_first > req_last;
    assign room      = count < CW'(FIFO_DEPTH);
    // The result is staged for one cycle, so the FIFO count already includes it
    // by the time the controller re-enters ISSUE and checks for room.
    assign capture   = (state == S_WAIT) && !skip_q && !pend_q && fib_done;
    assign push      = pend_q;
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        fib_go    = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid && !empty_req) state_nx = S_ISSUE;
            end
            S_ISSUE: begin
                if (room) begin
                    fib_go   = 1'b1;
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (pend_q) state_nx = st_last ? S_IDLE : S_ISSUE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            n_cnt     <= '0;
            last_q    <= '0;
            skip_q    <= 1'b0;
            pend_q    <= 1'b0;
            err_q     <= 1'b0;
            st_n      <= '0;
            st_result <= '0;
            st_ovf    <= 1'b0;
            st_last   <= 1'b0;
        end else begin
            state  <= state_nx;
            skip_q <= fib_go;
            pend_q <= capture;
            err_q  <= accept && empty_req;
            if (accept) begin
                n_cnt  <= {1'b0, req_first};
                last_q <= {1'b0, req_last};
            end else if ((state == S_WAIT) && pend_q && !st_last) begin
                n_cnt <= n_cnt + (INPUT_WIDTH + 1)'(1);
            end
            if (capture) begin
                st_n      <= n_cnt[INPUT_WIDTH-1:0];
                st_result <= fib_result;
                st_ovf    <= fib_overflow;
                st_last   <= (n_cnt == last_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_n[wr_ptr]      <= st_n;
            mem_result[wr_ptr] <= st_result;
            mem_ovf[wr_ptr]    <= st_ovf;
            mem_last[wr_ptr]   <= st_last;
        end
    end

    // Head is gated by out_valid so stale or uninitialised entries never show.
    assign out_valid    = (count != '0);
    assign out_n        = out_valid ? mem_n[rd_ptr]      : '0;
    assign out_result   = out_valid ? mem_result[rd_ptr] : '0;
    assign out_overflow = out_valid ? mem_ovf[rd_ptr]    : 1'b0;
    assign out_last     = out_valid ? mem_last[rd_ptr]   : 1'b0;
    assign fib_n        = n_cnt[INPUT_WIDTH-1:0];
    assign req_err      = err_q;
    assign busy         = (state != S_IDLE);
endmodule

// File: tb/tb_fib_batch_ctrl.sv
// tb/tb_fib_batch_ctrl.sv - scoreboard bench for fib_batch_ctrl with a behavioural fib core
module tb_fib_batch_ctrl;
    localparam int IW = 6;
    localparam int OW = 32;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_err;
    logic [IW-1:0] req_first, req_last;
    logic          fib_go, fib_done, fib_overflow;
    logic [IW-1:0] fib_n;
    logic [OW-1:0] fib_result;
    logic          out_valid, out_ready, out_overflow, out_last, busy;
    logic [IW-1:0] out_n;
    logic [OW-1:0] out_result;

    always #5 clk = ~clk;

    fib_batch_ctrl #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_first(req_first), .req_last(req_last), .req_err(req_err),
        .fib_go(fib_go), .fib_n(fib_n), .fib_done(fib_done),
        .fib_result(fib_result), .fib_overflow(fib_overflow),
        .out_valid(out_valid), .out_ready(out_ready), .out_n(out_n),
        .out_result(out_result), .out_overflow(out_overflow),
        .out_last(out_last), .busy(busy)
    );

    typedef struct {
        logic [IW-1:0] n;
        logic [OW-1:0] r;
        logic          o;
        logic          l;
    } tup_t;

    tup_t sb[$];
    tup_t popped[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   go_cnt  = 0;
    int   err_cnt = 0;
    int   rdy_mode = 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // fib(0)=0, fib(1)=0, fib(2)=1, ... i.e. the Fibonacci sequence delayed by one
    function automatic logic [63:0] fibp(input int n);
        logic [63:0] a, b, t;
        a = 0;
        b = 1;
        if (n == 0) return 64'd0;
        for (int i = 1; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic tup_t expect_tup(input int n, input int last);
        tup_t e;
        logic [63:0] v;
        v   = fibp(n);
        e.n = n[IW-1:0];
        e.r = v[OW-1:0];
        e.o = (v >= 64'h1_0000_0000);
        e.l = (n == last);
        return e;
    endfunction

    // Fib core model: random latency, done held as a level until the next go
    initial begin
        int cd;
        logic [IW-1:0] core_n;
        logic [63:0]   v;
        cd = -1;
        core_n = '0;
        fib_done = 1'b0;
        fib_result = '0;
        fib_overflow = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                fib_done = 1'b0;
                cd = -1;
            end else if (fib_go) begin
                go_cnt++;
                core_n = fib_n;
                fib_done = 1'b0;
                fib_result = $urandom;
                fib_overflow = 1'($urandom_range(0, 1));
                cd = $urandom_range(2, 6);
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    chk("fib_n_held", fib_n, core_n);
                    v = fibp(int'(core_n));
                    fib_result = v[OW-1:0];
                    fib_overflow = (v >= 64'h1_0000_0000);
                    fib_done = 1'b1;
                    cd = -1;
                end
            end
        end
    end

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks stall stability
    initial begin
        logic stall;
        tup_t held, e, cur;
        stall = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
            end else begin
                if (req_err) err_cnt++;
                cur.n = out_n; cur.r = out_result; cur.o = out_overflow; cur.l = out_last;
                if (stall && out_valid) begin
                    chk("stall_n", cur.n, held.n);
                    chk("stall_result", cur.r, held.r);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("spurious_out", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("out_n", cur.n, e.n);
                        chk("out_result", cur.r, e.r);
                        chk("out_overflow", cur.o, e.o);
                        chk("out_last", cur.l, e.l);
                    end
                    popped.push_back(cur);
                    stall = 1'b0;
                end else begin
                    stall = out_valid;
                    held = cur;
                end
            end
        end
    end

    task automatic tick(input int k = 1);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic send(input int f, input int l);
        int t;
        t = 0;
        while (busy && t < 3000) begin
            tick();
            t++;
        end
        if (t >= 3000) chk("idle_timeout", 1, 0);
        req_first = f[IW-1:0];
        req_last  = l[IW-1:0];
        req_valid = 1'b1;
        if (f <= l)
            for (int n = f; n <= l; n++) sb.push_back(expect_tup(n, l));
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while ((busy || sb.size() != 0) && t < 5000) begin
            tick();
            t++;
        end
        if (t >= 5000) chk("drain_timeout", 1, 0);
        tick(2);
    endtask

    initial begin
        int g0, e0, e_exp, bad, f, l, t;
        int t1_exp[10];
        t1_exp = '{0, 0, 1, 1, 2, 3, 5, 8, 13, 21};
        rst = 1'b1;
        req_valid = 1'b0;
        req_first = '0;
        req_last  = '0;
        tick(3);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_req_err", req_err, 0);
        chk("rst_fib_go", fib_go, 0);
        chk("rst_fib_n", fib_n, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_n", out_n, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_overflow", out_overflow, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        tick(2);

        rdy_mode = 1;
        popped.delete();
        send(0, 9);
        wait_done();
        chk("b0_9_count", popped.size(), 10);
        if (popped.size() == 10)
            for (int i = 0; i < 10; i++) chk("b0_9_value", popped[i].r, t1_exp[i]);

        rdy_mode = 0;
        popped.delete();
        g0 = go_cnt;
        send(10, 17);
        tick(60);
        chk("full_go_count", go_cnt - g0, D);
        chk("full_out_valid", out_valid, 1);
        chk("full_out_n", out_n, 10);
        tick(10);
        chk("full_go_hold", go_cnt - g0, D);
        chk("full_out_n_hold", out_n, 10);
        rdy_mode = 1;
        wait_done();
        chk("b10_17_count", popped.size(), 8);
        if (popped.size() == 8) chk("b10_17_n17", popped[7].r, 987);

        popped.delete();
        send(47, 49);
        wait_done();
        chk("b47_count", popped.size(), 3);
        if (popped.size() == 3) begin
            chk("b47_r", popped[0].r, 1836311903);
            chk("b48_r", popped[1].r, 64'd2971215073);
            chk("b48_o", popped[1].o, 0);
            chk("b49_o", popped[2].o, 1);
            chk("b49_l", popped[2].l, 1);
        end

        g0 = go_cnt;
        e0 = err_cnt;
        bad = 0;
        send(5, 3);
        for (int i = 0; i < 10; i++) begin
            if (!req_ready || out_valid || busy) bad++;
            tick();
        end
        chk("err_pulses", err_cnt - e0, 1);
        chk("err_no_go", go_cnt - g0, 0);
        chk("err_quiet_cycles", bad, 0);

        popped.delete();
        g0 = go_cnt;
        send(63, 63);
        wait_done();
        chk("b63_count", popped.size(), 1);
        if (popped.size() == 1) begin
            chk("b63_n", popped[0].n, 63);
            chk("b63_o", popped[0].o, 1);
            chk("b63_l", popped[0].l, 1);
        end
        tick(10);
        chk("b63_go_once", go_cnt - g0, 1);
        chk("b63_busy", busy, 0);

        rdy_mode = 0;
        g0 = go_cnt;
        send(0, 9);
        t = 0;
        while (go_cnt - g0 < 3 && t < 500) begin
            tick();
            t++;
        end
        chk("mid_reset_reach", go_cnt - g0, 3);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        sb.delete();
        tick();
        rst = 1'b0;
        g0 = go_cnt;
        tick(20);
        chk("post_rst_no_go", go_cnt - g0, 0);
        rdy_mode = 1;
        popped.delete();
        send(3, 3);
        wait_done();
        chk("post_rst_count", popped.size(), 1);
        if (popped.size() == 1) begin
            chk("post_rst_n", popped[0].n, 3);
            chk("post_rst_r", popped[0].r, 1);
        end

        rdy_mode = 2;
        e0 = err_cnt;
        e_exp = 0;
        for (int k = 0; k < 25; k++) begin
            f = $urandom_range(0, 63);
            if (f > 0 && $urandom_range(0, 5) == 0) begin
                l = f - 1;
                e_exp++;
            end else begin
                l = f + $urandom_range(0, 6);
                if (l > 63) l = 63;
            end
            send(f, l);
            wait_done();
        end
        chk("rand_err_count", err_cnt - e0, e_exp);
        chk("rand_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fib_batch_ctrl.md
FIB_BATCH_CTRL -- requirements
Module: fib_batch_ctrl

Interface
REQ-001 Parameter INPUT_WIDTH, default 6, width of n values.
REQ-002 Parameter OUTPUT_WIDTH, default 32, width of fib results.
REQ-003 Parameter FIFO_DEPTH, default 4, output buffer entries, power of two, at least 2.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  1  batch request present.
REQ-007 req_ready  output  1  controller can accept a request.
REQ-008 req_first  input  INPUT_WIDTH  first n of batch.
REQ-009 req_last  input  INPUT_WIDTH  last n of batch, inclusive.
REQ-010 req_err  output  1  one-cycle pulse: accepted request was empty.
REQ-011 fib_go  output  1  one-cycle start pulse to the fib core.
REQ-012 fib_n  output  INPUT_WIDTH  n presented to the fib core.
REQ-013 fib_done  input  1  fib core completion.
REQ-014 fib_result  input  OUTPUT_WIDTH  fib core result.
REQ-015 fib_overflow  input  1  fib core overflow flag.
REQ-016 out_valid  output  1  FIFO head valid.
REQ-017 out_ready  input  1  consumer accepts head.
REQ-018 out_n  output  INPUT_WIDTH  n of head tuple.
REQ-019 out_result  output  OUTPUT_WIDTH  result of head tuple.
REQ-020 out_overflow  output  1  overflow of head tuple.
REQ-021 out_last  output  1  head tuple is the last of its batch.
REQ-022 busy  output  1  high whenever state is not IDLE.

Function
REQ-023 States: IDLE, ISSUE, WAIT. The next state is decided on every clk edge.
REQ-024 IDLE: req_ready=1. A request is accepted on req_valid&&req_ready. The controller latches first/last. The n counter is INPUT_WIDTH+1 bits wide and loads first.
REQ-025 Accept with req_first>req_last: req_err=1 for the next cycle, the state stays IDLE, and no FIFO push occurs.
REQ-026 Accept with req_first<=req_last: the state goes to ISSUE.
REQ-027 ISSUE: fib_go=1 for exactly one cycle, only when FIFO count<FIFO_DEPTH. Otherwise the state stays in ISSUE with fib_go=0. The state then goes to WAIT.
REQ-028 fib_n shall equal the current n counter, held stable from ISSUE through WAIT.
REQ-029 WAIT: fib_done is ignored in the first cycle after fib_go. After that, the first cycle with fib_done=1 pushes {n, fib_result, fib_overflow, n==last} into the FIFO.
REQ-030 Fib core contract: fib_done is low from the cycle after fib_go until the result is valid.
REQ-031 After a push with n==last, the state goes to IDLE. Otherwise n increments and the state goes to ISSUE.
REQ-032 A request with req_last = 2^INPUT_WIDTH-1 shall terminate without counter wrap.
REQ-033 The FIFO pops on out_valid&&out_ready. out_* shall reflect the head combinationally from registers. out_valid=(count!=0).
REQ-034 A simultaneous push and pop leaves count unchanged. A push never occurs when full, per REQ-027. A pop when empty is ignored.
REQ-035 out_* shall hold stable while out_valid=1 and out_ready=0.
REQ-036 Only one fib operation is in flight at a time. Outputs are produced in ascending n order.
REQ-037 Latency: push occurs one cycle after the qualifying fib_done. out_valid rises the cycle after push when the FIFO was empty.

Reset
REQ-038 When rst=1, the following shall clear immediately: state=IDLE, FIFO count, read and write pointers =0, n counter=0.
REQ-039 Reset values: req_ready=1, req_err=0, fib_go=0, fib_n=0, out_valid=0, out_n=0, out_result=0, out_overflow=0, out_last=0, busy=0.
REQ-040 Reset mid-batch discards buffered tuples and the in-flight operation. After reset deasserts, no fib_go is issued until a new request is accepted.

Verification
REQ-041 Request 0..9 with out_ready=1 -> 10 tuples with n=0..9. Results 0,0,1,1,2,3,5,8,13,21, overflow=0 for all. out_last=1 only on n=9.
REQ-042 Request 10..17 with out_ready=0 -> after 4 tuples, fib_go stays 0 and out_n=10 stays stable. Raising out_ready -> all 8 tuples delivered in order, with n=17 result 987.
REQ-043 Request 47..49 -> (47, 1836311903, 0), (48, 2971215073, 0), (49, overflow=1, out_last=1).
REQ-044 Request first=5, last=3 -> single req_err pulse, no fib_go, no out_valid. req_ready=1 throughout.
REQ-045 Request 63..63 -> exactly one tuple with n=63, overflow=1, out_last=1. busy returns to 0 with no further fib_go.
REQ-046 rst pulsed during WAIT of request 0..9 with 2 tuples buffered -> out_valid=0 and busy=0 immediately. The next request 3..3 yields a single tuple (3, 1).
